keystream_xor_stream: RTL and testbench
=======================================

// Module: keystream_xor_stream
// PURPOSE
//  Parametrised TX cipher datapath: buffers 512-bit keystream blocks from the chacha20 core,
//  slices them into C_DATA_WIDTH words and XORs them onto an AXI-Stream payload with full backpressure.
//  Adds tlast/sof framing, a keystream prefetch FIFO, block counting and a keystream timeout.
//  Sits between the tx control regs / chacha20_inst and the downstream modulator stream.
// PARAMETERS
//  C_DATA_WIDTH   32   stream width; one of 32/64/128/256/512 (must divide 512)
//  C_KS_DEPTH     2    keystream FIFO depth in 512-bit blocks (1..4)
//  C_CNT_WIDTH    32   width of consumed-block counter
//  C_KS_TIMEOUT   1024 max cycles from o_ks_req to i_ks_valid before error
// PORTS
//  i_aclk           in  1      clock
//  i_areset         in  1      synchronous reset, active-high
//  i_enable         in  1      allow input acceptance (tx_enable)
//  i_reload         in  1      1-cycle pulse: key/nonce reloaded; flush keystream state
//  o_ks_req         out 1      1-cycle request for one keystream block
//  i_ks_busy        in  1      chacha20 core busy
//  i_ks_data        in  512    keystream block, word 0 = bits[C_DATA_WIDTH-1:0]
//  i_ks_valid       in  1      1-cycle strobe, i_ks_data valid
//  s_axis_tvalid/tready/tdata[C_DATA_WIDTH]/tlast   plaintext in (tready out)
//  m_axis_tvalid/tready/tdata[C_DATA_WIDTH]/tlast   ciphertext out (tready in)
//  m_axis_sof       out 1      first beat of frame, qualified by m_axis_tvalid
//  o_block_count    out C_CNT_WIDTH  blocks fully consumed since reset/reload
//  o_error          out 1      sticky keystream timeout
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; word index 0; sof_pending=1; FSM IDLE.
//  WORDS = 512/C_DATA_WIDTH. Refill FSM: IDLE -> (fill+outstanding < C_KS_DEPTH && !i_ks_busy) REQ
//   (o_ks_req=1 one cycle) -> WAIT -> (i_ks_valid) push block, IDLE; WAIT timer hits C_KS_TIMEOUT
//   -> o_error=1, IDLE (re-request). One request outstanding max; FIFO can never overflow.
//  s_axis_tready = i_enable && fifo_not_empty && (!m_axis_tvalid || m_axis_tready); combinational.
//  Input handshake: output reg loads tdata ^ ks_word[idx], tlast, sof=sof_pending; latency 1 cycle.
//   idx++; at idx==WORDS-1 pop head block, idx=0, o_block_count++ (wraps to 0 at all-ones, no flag).
//  sof_pending: cleared on accepted beat, set on accepted beat with tlast and on reload.
//  Output held stable while m_axis_tvalid && !m_axis_tready (AXIS rule); tvalid drops when
//   consumed and no new beat accepted the same cycle.
//  i_enable low: no new input accepted; pending output beat still drains; refill continues.
//  i_reload: FIFO flushed, idx=0, o_block_count=0, o_error cleared, sof_pending=1, FSM IDLE;
//   if a request is outstanding the next i_ks_valid is discarded. Output register not flushed.
//  Simultaneous pop (last word) and push: both occur; fill unchanged.
//  i_reload and input handshake same cycle: reload wins, beat NOT accepted (tready forced 0).
//  Reset mid-frame: everything returns to reset state; downstream sees tvalid drop immediately.
// CONFIGURATION
//  KS_FRAME_ALIGN_EN defined: accepted beat with tlast also pops the head block (idx=0, count++)
//   so every frame starts at keystream word 0 of a fresh block.
//  Not defined: keystream continues across frame boundaries; tlast affects only framing/sof.
// STRUCTURE
//  keystream_pkg.vh: KS_BLOCK_BITS=512, FSM state encodings (IDLE/REQ/WAIT), WORDS function.
//  Sub-module ks_block_fifo: C_KS_DEPTH x 512 synchronous FIFO, push/pop/flush, fill count,
//   head-word mux by idx. Top holds FSM, timer, output register, framing, counter.
// TESTING
//  C_DATA_WIDTH=32, ks block = 16 words 0x0..0xF, tdata=0xA5A5A5A5 x16 -> tdata out 0xA5A5A5A5^i, count=1.
//  m_axis_tready toggled 1010.. over 40 beats -> no beat lost/duplicated, data stable while stalled.
//  C_KS_DEPTH=2, core never asserts i_ks_valid -> o_error=1 after 1024 cycles, o_ks_req re-pulsed.
//  Frame of 5 words tlast on 5th, then new frame: sof on beats 1 and 6; with KS_FRAME_ALIGN_EN
//   beat 6 uses ks word 0 of block 2, count=1; without, uses word 5 of block 1, count=0.
//  i_reload mid-block (idx=7) with request outstanding -> late i_ks_valid dropped, next beat uses
//   word 0 of first post-reload block, o_block_count=0, sof=1.
//  C_DATA_WIDTH=128, counter preset path: 2^C_CNT_WIDTH blocks (C_CNT_WIDTH=4) -> count wraps 15->0.

Source files
------------

// File: rtl/keystream_xor_stream_pkg.sv
// Shared constants, refill FSM states and word-count helper
// for the keystream XOR stream datapath.
package keystream_xor_stream_pkg;

    localparam int KS_BLOCK_BITS = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } ks_state_e;

    function automatic int ks_words(input int width);
        return KS_BLOCK_BITS / width;
    endfunction

endpackage

// File: rtl/keystream_xor_stream_ks_block_fifo.sv
// ks_block_fifo: C_KS_DEPTH x 512-bit keystream block FIFO with
// flush, fill count and head-block word select.
module ks_block_fifo
    import keystream_xor_stream_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_KS_DEPTH   = 2,
    parameter int C_IDX_WIDTH  = 4,
    parameter int C_FILL_WIDTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [KS_BLOCK_BITS-1:0] i_data,
    input  logic                     i_pop,
    input  logic [C_IDX_WIDTH-1:0]   i_idx,
    output logic [C_FILL_WIDTH-1:0]  o_fill,
    output logic [C_DATA_WIDTH-1:0]  o_word
);

    localparam int WORDS = ks_words(C_DATA_WIDTH);
    localparam int PW    = (C_KS_DEPTH > 1) ? $clog2(C_KS_DEPTH) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(C_KS_DEPTH - 1);

    logic [KS_BLOCK_BITS-1:0] r_mem [C_KS_DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [C_FILL_WIDTH-1:0]  r_fill;
    logic [WORDS-1:0][C_DATA_WIDTH-1:0] w_head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + 1'b1;
    endfunction

    // Block storage; no reset needed, validity tracked by fill
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and fill; flush empties without touching storage
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign o_word = w_head[i_idx];
    assign o_fill = r_fill;

endmodule

// File: rtl/keystream_xor_stream.sv
// keystream_xor_stream: XORs buffered chacha20 keystream onto an AXIS payload.
// Build option KS_FRAME_ALIGN_EN: tlast retires the head block so frames start at word 0.
module keystream_xor_stream
    import keystream_xor_stream_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_KS_DEPTH   = 2,
    parameter int C_CNT_WIDTH  = 32,
    parameter int C_KS_TIMEOUT = 1024
) (
    input  logic                     i_aclk,
    input  logic                     i_areset,
    input  logic                     i_enable,
    input  logic                     i_reload,
    output logic                     o_ks_req,
    input  logic                     i_ks_busy,
    input  logic [KS_BLOCK_BITS-1:0] i_ks_data,
    input  logic                     i_ks_valid,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic                     m_axis_sof,
    output logic [C_CNT_WIDTH-1:0]   o_block_count,
    output logic                     o_error
);

    localparam int WORDS = ks_words(C_DATA_WIDTH);
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int FW    = $clog2(C_KS_DEPTH + 1);
    localparam int TW    = $clog2(C_KS_TIMEOUT + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(C_KS_TIMEOUT - 1);
    localparam logic [FW-1:0] DEPTH_F  = FW'(C_KS_DEPTH);

    ks_state_e               r_state;
    ks_state_e               w_next;
    logic [TW-1:0]           r_timer;
    logic                    r_discard;
    logic [IW-1:0]           r_idx;
    logic [C_CNT_WIDTH-1:0]  r_cnt;
    logic                    r_err;
    logic                    r_sof_pend;
    logic                    r_tvalid;
    logic [C_DATA_WIDTH-1:0] r_tdata;
    logic                    r_tlast;
    logic                    r_sof;
    logic [FW-1:0]           w_fill;
    logic [C_DATA_WIDTH-1:0] w_word;
    logic                    w_req;
    logic                    w_timeout;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_ready;
    logic                    w_acc;

    ks_block_fifo #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_KS_DEPTH   (C_KS_DEPTH),
        .C_IDX_WIDTH  (IW),
        .C_FILL_WIDTH (FW)
    ) u_fifo (
        .i_clk   (i_aclk),
        .i_rst   (i_areset),
        .i_flush (i_reload),
        .i_push  (w_push),
        .i_data  (i_ks_data),
        .i_pop   (w_pop),
        .i_idx   (r_idx),
        .o_fill  (w_fill),
        .o_word  (w_word)
    );

    // Refill state register
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Refill next-state: one request in flight, only when a slot is free
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fill < DEPTH_F && !i_ks_busy) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_req  = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_ks_valid && !r_discard) begin
                    w_next = ST_IDLE;
                end else if (r_timer == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (i_reload) begin
            w_next = ST_IDLE;
        end
    end

    assign w_push = (r_state == ST_WAIT) && i_ks_valid
                    && !r_discard && !i_reload;

    // Wait timer and drop flag for a response to a pre-reload request
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_timer   <= '0;
            r_discard <= 1'b0;
        end else begin
            r_timer <= (r_state == ST_WAIT) ? r_timer + 1'b1 : '0;
            if (i_reload) begin
                r_discard <= !i_ks_valid
                             && (r_discard || r_state != ST_IDLE);
            end else if (i_ks_valid) begin
                r_discard <= 1'b0;
            end
        end
    end

    // Sticky keystream timeout, cleared by reload
    always_ff @(posedge i_aclk) begin
        if (i_areset || i_reload) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign w_ready = i_enable && (w_fill != '0)
                     && (!r_tvalid || m_axis_tready) && !i_reload;
    assign w_acc   = s_axis_tvalid && w_ready;

`ifdef KS_FRAME_ALIGN_EN
    assign w_pop = w_acc && (r_idx == IDX_LAST || s_axis_tlast);
`else
    assign w_pop = w_acc && (r_idx == IDX_LAST);
`endif

    // Word index, consumed-block counter and start-of-frame tracking
    always_ff @(posedge i_aclk) begin
        if (i_areset || i_reload) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_sof_pend <= 1'b1;
        end else if (w_acc) begin
            r_idx      <= w_pop ? '0 : r_idx + 1'b1;
            r_sof_pend <= s_axis_tlast;
            if (w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register: load on accept, hold while stalled
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_sof    <= 1'b0;
        end else if (w_acc) begin
            r_tvalid <= 1'b1;
            r_tdata  <= s_axis_tdata ^ w_word;
            r_tlast  <= s_axis_tlast;
            r_sof    <= r_sof_pend;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign o_ks_req      = w_req;
    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_sof    = r_sof;
    assign o_block_count = r_cnt;
    assign o_error       = r_err;

endmodule

// File: tb/tb_keystream_xor_stream.sv
// Bench for keystream_xor_stream: scoreboarded 32-bit instance plus
// a 128-bit / 4-bit-counter instance for the counter wrap.
`timescale 1ns/1ps
module tb_keystream_xor_stream;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        s;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, enable, reload, ks_busy, ks_valid, ks_req;
    logic [511:0] ks_data;
    logic         s_tvalid, s_tready, s_tlast;
    logic [31:0]  s_tdata;
    logic         m_tvalid, m_tlast, m_tsof;
    logic         m_tready = 1'b1;
    logic [31:0]  m_tdata, blk_cnt;
    logic         err;

    logic         ks_req2, s2_tvalid, s2_tready;
    logic         ks_valid2 = 1'b0;
    logic         reload2 = 1'b0, busy2 = 1'b0, s2_tlast = 1'b0;
    logic         m2_tready = 1'b1;
    logic [511:0] ks_data2 = {16{32'h13579BDF}};
    logic [127:0] s2_tdata, m2_tdata;
    logic         m2_tvalid, m2_tlast, m2_tsof, err2;
    logic [3:0]   cnt2;

    keystream_xor_stream u_dut (
        .i_aclk(clk), .i_areset(rst), .i_enable(enable),
        .i_reload(reload), .o_ks_req(ks_req), .i_ks_busy(ks_busy),
        .i_ks_data(ks_data), .i_ks_valid(ks_valid),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .m_axis_sof(m_tsof), .o_block_count(blk_cnt), .o_error(err)
    );

    keystream_xor_stream #(
        .C_DATA_WIDTH(128), .C_KS_DEPTH(2),
        .C_CNT_WIDTH(4), .C_KS_TIMEOUT(1024)
    ) u_dut2 (
        .i_aclk(clk), .i_areset(rst), .i_enable(enable),
        .i_reload(reload2), .o_ks_req(ks_req2), .i_ks_busy(busy2),
        .i_ks_data(ks_data2), .i_ks_valid(ks_valid2),
        .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
        .s_axis_tdata(s2_tdata), .s_axis_tlast(s2_tlast),
        .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
        .m_axis_tdata(m2_tdata), .m_axis_tlast(m2_tlast),
        .m_axis_sof(m2_tsof), .o_block_count(cnt2), .o_error(err2)
    );

    int   checks = 0, errors = 0;
    exp_t sbq[$];
    int   m_blk, m_idx, m_cnt;
    logic mdl_sof;
    int   rsp_id = 0, ks_lat = 0, rsp_b, nreq = 0;
    bit   ks_auto = 1'b1, tog = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkword(input int b, input int i);
        return 32'(b * 256 + i);
    endfunction

    function automatic logic [511:0] mkblk(input int b);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = mkword(b, i);
        return v;
    endfunction

    // chacha20 stand-in: block b holds words (b<<8)|i
    always begin
        @(negedge clk);
        if (ks_req && ks_auto && !rst) begin
            rsp_b = rsp_id;
            rsp_id++;
            @(posedge clk); #1;
            ks_busy = 1'b1;
            repeat (ks_lat) begin @(posedge clk); #1; end
            ks_data  = mkblk(rsp_b);
            ks_valid = 1'b1;
            @(posedge clk); #1;
            ks_valid = 1'b0;
            ks_busy  = 1'b0;
        end
    end

    always @(posedge clk) ks_valid2 <= ks_req2;

    always @(posedge clk) begin
        #1;
        m_tready = tog ? ~m_tready : 1'b1;
    end

    always @(negedge clk) if (ks_req) nreq++;

    // Output monitor: stall stability and in-order scoreboard
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    exp_t        e;
    always @(negedge clk) begin
        if (hold_v) begin
            chk("stall_valid", m_tvalid, 1);
            chk("stall_data", m_tdata, hold_d);
        end
        hold_v = m_tvalid && !m_tready;
        hold_d = m_tdata;
        if (m_tvalid && m_tready) begin
            chk("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("data", m_tdata, e.d);
                chk("last", m_tlast, e.l);
                chk("sof", m_tsof, e.s);
            end
        end
    end

    task automatic set_model();
        m_blk = rsp_id; m_idx = 0; mdl_sof = 1'b1; m_cnt = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int   n;
        logic acc, pop;
        n = 0; acc = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        while (!acc && n < 2000) begin
            @(negedge clk);
            n++;
            acc = s_tready;
        end
        chk("accept", acc, 1);
        if (acc) begin
            sbq.push_back(exp_t'{d: d ^ mkword(m_blk, m_idx),
                                 l: l, s: mdl_sof});
            mdl_sof = l;
            pop = (m_idx == 15);
`ifdef KS_FRAME_ALIGN_EN
            pop = pop || l;
`endif
            if (pop) begin m_blk++; m_idx = 0; m_cnt++; end
            else m_idx++;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send2(input logic [127:0] d);
        int   n;
        logic acc;
        n = 0; acc = 1'b0;
        s2_tvalid = 1'b1; s2_tdata = d;
        while (!acc && n < 2000) begin
            @(negedge clk);
            n++;
            acc = s2_tready;
        end
        chk("accept2", acc, 1);
        @(posedge clk); #1;
        s2_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        set_model();
    endtask

    int n0;
    initial begin
        rst = 1; enable = 0; reload = 0; ks_busy = 0; ks_valid = 0;
        ks_data = '0; s_tvalid = 0; s_tdata = '0; s_tlast = 0;
        s2_tvalid = 0; s2_tdata = '0;
        m_blk = 0; m_idx = 0; m_cnt = 0; mdl_sof = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_req", ks_req, 0);
        chk("rst_cnt", blk_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_sof", m_tsof, 0);
        @(posedge clk); #1;
        rst = 0; enable = 1;
        repeat (20) @(posedge clk);
        #1;

        // one full block of 0xA5A5A5A5
        for (int i = 0; i < 16; i++) send(32'hA5A5A5A5, i == 15);
        drain();
        chk("t1_cnt", blk_cnt, 1);

        // 40 beats under alternating backpressure
        tog = 1'b1;
        for (int i = 0; i < 40; i++) send($urandom, i == 39);
        drain();
        tog = 1'b0;
        chk("t2_cnt", blk_cnt, m_cnt);

        // two frames: 5 beats then 3 beats
        repeat (40) @(posedge clk);
        #1;
        do_reload();
        @(negedge clk);
        chk("t3_cnt0", blk_cnt, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(32'h1000 + i, i == 4);
        drain();
`ifdef KS_FRAME_ALIGN_EN
        chk("t3_cnt", blk_cnt, 1);
`else
        chk("t3_cnt", blk_cnt, 0);
`endif

        // reload at idx 7 with a slow request in flight
        repeat (40) @(posedge clk);
        #1;
        ks_lat = 20;
        do_reload();
        for (int i = 0; i < 23; i++) send(32'h2000 + i, 1'b0);
        s_tvalid = 1'b1; s_tdata = 32'hDEAD0000; reload = 1'b1;
        @(negedge clk);
        chk("t4_tready_reload", s_tready, 0);
        @(posedge clk); #1;
        reload = 1'b0; s_tvalid = 1'b0;
        set_model();
        ks_lat = 0;
        @(negedge clk);
        chk("t4_tready_empty", s_tready, 0);
        chk("t4_cnt0", blk_cnt, 0);
        @(posedge clk); #1;
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        drain();
        chk("t4_err", err, 0);

        // keystream never arrives
        repeat (40) @(posedge clk);
        #1;
        ks_auto = 1'b0;
        do_reload();
        n0 = nreq;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("t5_err_early", err, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t5_err", err, 1);
        chk("t5_rereq", (nreq - n0) >= 2, 1);
        @(posedge clk); #1;
        do_reload();
        @(negedge clk);
        chk("t5_err_clr", err, 0);

        // reset returns everything to idle
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_tvalid", m_tvalid, 0);
        chk("t6_cnt", blk_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // 128-bit instance: data path and 4-bit counter wrap
        send2(128'h0);
        @(negedge clk);
        chk("d2_data", m2_tdata, {4{32'h13579BDF}});
        chk("d2_sof", m2_tsof, 1);
        chk("d2_last", m2_tlast, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 59; i++) send2({4{$urandom}});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("d2_cnt15", cnt2, 4'd15);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send2(128'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("d2_wrap", cnt2, 4'd0);
        chk("d2_err", err2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
